dag_addr_gen: RTL and testbench
===============================

Name: dag_addr_gen

Overview:
- Data address generator (DAG). Sits directly downstream of the program sequencer and consumes its DAG decode outputs (ps_dg_*). Feeds back jump targets on dg_ps_add and drives data-memory addresses.
- Holds 8 index (I), 8 modify (M), 8 length (L) and 8 base (B) registers, each 16 bits.
- Performs pre- or post-modify address generation, with optional circular buffering.
- Registers are read and written as universal registers over the bus connect.

Parameters:
- AW, 16, address/register width.
- NREG, 8, registers per group (I/M/L/B); index width is log2(NREG)=3.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- ps_dg_en  in  1  perform address generation this cycle.
- ps_dg_dgsclt  in  1  1 = pre-modify (output I+M); 0 = post-modify (output I).
- ps_dg_mdfy  in  1  1 = write the modified address back to I[iadd].
- ps_dg_iadd  in  3  I register select.
- ps_dg_madd  in  3  M register select.
- ps_dg_wrt_en  in  1  ureg write strobe.
- ps_dg_wrt_add  in  5  ureg write address: [4:3] group (00=I, 01=M, 10=L, 11=B), [2:0] index.
- ps_dg_rd_add  in  5  ureg read address, same encoding.
- bc_dt  in  AW  ureg write data from the bus connect.
- dg_ps_add  out  AW  generated address to the sequencer (jump target).
- dg_dm_add  out  AW  generated address to data memory.
- dg_add_vld  out  1  dg_ps_add/dg_dm_add valid.
- dg_bc_dt  out  AW  ureg read data to the bus connect.

Behaviour:
- Reset (rst=1 at posedge clk): all I/M/L/B = 0; dg_ps_add = 0, dg_dm_add = 0, dg_add_vld = 0. Reset mid-operation discards any pending update; outputs read 0 the following cycle.
- Modify sum: nxt = I[iadd] + M[madd]. M is two's-complement signed; the sum is mod 2^16 (wraps, no saturation).
- Address out: dgsclt=1 -> addr = nxt; dgsclt=0 -> addr = I[iadd].
- Latency: addr is registered. dg_ps_add = dg_dm_add = addr, and dg_add_vld = 1, exactly one clk after the ps_dg_en cycle. dg_add_vld = 0 in cycles with ps_dg_en = 0. Address outputs hold their last value while dg_add_vld = 0.
- Writeback: if ps_dg_en & ps_dg_mdfy, I[iadd] <= nxt at the same edge that registers the address.
- Ureg write: if ps_dg_wrt_en, the addressed register <= bc_dt at the edge.
- Write collision: a ureg write to I[k] and a modify writeback to I[k] in the same cycle -> the ureg write wins and the writeback is dropped.
- Back-to-back: consecutive ps_dg_en cycles on the same I see the updated value. The combinational nxt uses the register, and the register is written at each edge, so no hazard exists.
- Ureg read: dg_bc_dt is combinational from ps_dg_rd_add.
- Read bypass: if ps_dg_wrt_en and wrt_add == rd_add, dg_bc_dt = bc_dt.
- Generation operands: the I/M values used for generation are NOT bypassed from same-cycle ureg writes. They use the pre-edge register contents; the sequencer guarantees separation.
- Undriven groups return 0 on read (see Optional Feature).

Optional Feature:
- Macro: DAG_CIRC_BUF_EN.
- Defined, L[iadd] != 0:
  - nxt is wrapped into [B[iadd], B[iadd]+L[iadd]).
  - If raw >= B+L, nxt = raw - L. If raw < B, nxt = raw + L.
  - Requires |M| <= L; this is the single-correction rule.
- Defined, L[iadd] == 0: linear, same as undefined.
- Not defined:
  - No L/B storage is synthesized.
  - Writes to groups 10/11 are ignored.
  - Reads of groups 10/11 return 0.
  - nxt is always linear.

Decomposition:
- dag_pkg holds:
  - group codes GRP_I=2'b00, GRP_M=2'b01, GRP_L=2'b10, GRP_B=2'b11;
  - AW and NREG defaults;
  - a ureg address field-extract helper.
- One sub-module, dag_circ_mod: combinational (I, M, B, L) -> nxt, including the circular wrap.
- The register banks and control remain in dag_addr_gen.

Test Plan:
1. Reset then read all 32 ureg addresses -> all 0; dg_add_vld=0, dg_ps_add=0.
2. Write I2=0x0100 and M3=0x0004. Then en, dgsclt=0, mdfy=1, iadd=2, madd=3 -> next cycle dg_dm_add=0x0100, vld=1, and I2 reads 0x0104. A repeat gives 0x0104, then I2=0x0108.
3. Pre-modify: I1=0xFFFE, M0=0x0003, dgsclt=1, mdfy=0 -> dg_ps_add=0x0001 (wrap); I1 stays 0xFFFE.
4. Collision: en+mdfy on I4 and ureg write I4=0x1234 in the same cycle -> I4=0x1234. Same-cycle read of I4 returns 0x1234 via bypass.
5. With DAG_CIRC_BUF_EN: B5=0x0200, L5=0x0010, I5=0x020E, M1=0x0004, post-modify -> outputs 0x020E, I5=0x0202. M1=0xFFF8 from I5=0x0202 -> I5=0x020A.
6. Reset asserted in the cycle after en -> outputs 0 and vld=0; the I update from the discarded cycle is absent.

Source files
------------

// File: rtl/dag_pkg.sv
// Shared definitions for the data address generator: ureg group codes, default sizes
// and the ureg address field-extract helper.
package dag_pkg;

   localparam int DAG_AW   = 16;
   localparam int DAG_NREG = 8;
   localparam int DAG_IW   = $clog2(DAG_NREG);
   localparam int DAG_UAW  = DAG_IW + 2;

   typedef enum logic [1:0] {
      GRP_I = 2'b00,
      GRP_M = 2'b01,
      GRP_L = 2'b10,
      GRP_B = 2'b11
   } grp_e;

   typedef struct packed {
      grp_e              grp;
      logic [DAG_IW-1:0] idx;
   } ureg_addr_t;

   // Ureg address layout is {group[1:0], index}
   function automatic ureg_addr_t ureg_decode(input logic [DAG_UAW-1:0] addr);
      ureg_addr_t r;
      r.grp = grp_e'(addr[DAG_UAW-1 -: 2]);
      r.idx = addr[DAG_IW-1:0];
      return r;
   endfunction

endpackage

// File: rtl/dag_circ_mod.sv
// Combinational modify adder: nxt = I + M (M signed, mod 2^AW), with the optional
// single-correction circular wrap into [B, B+L) when DAG_CIRC_BUF_EN is defined.
module dag_circ_mod #(
   parameter int AW = 16
) (
   input  logic [AW-1:0] idx_i,
   input  logic [AW-1:0] mod_i,
   input  logic [AW-1:0] base_i,
   input  logic [AW-1:0] len_i,
   output logic [AW-1:0] nxt_o
);

   logic signed [AW+1:0] raw;

`ifdef DAG_CIRC_BUF_EN
   logic signed [AW+1:0] lo;
   logic signed [AW+1:0] hi;
   logic signed [AW+1:0] len;

   // Two guard bits keep B+L and I+M exact so the bounds compare without wrap artefacts
   always_comb begin
      len = $signed({2'b00, len_i});
      lo  = $signed({2'b00, base_i});
      hi  = lo + len;
      raw = $signed({2'b00, idx_i}) + $signed({{2{mod_i[AW-1]}}, mod_i});
      if (len_i != '0) begin
         if (raw >= hi) begin
            raw = raw - len;
         end else if (raw < lo) begin
            raw = raw + len;
         end
      end
   end
`else
   logic unusedBaseLen;
   assign unusedBaseLen = ^{base_i, len_i};

   always_comb begin
      raw = $signed({2'b00, idx_i}) + $signed({{2{mod_i[AW-1]}}, mod_i});
   end
`endif

   assign nxt_o = raw[AW-1:0];

endmodule

// File: rtl/dag_addr_gen.sv
// Data address generator: I/M (and, with DAG_CIRC_BUF_EN, L/B) register banks, registered
// pre/post-modify address output, modify writeback and universal-register access.
module dag_addr_gen
   import dag_pkg::*;
#(
   parameter int AW   = DAG_AW,
   parameter int NREG = DAG_NREG
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    ps_dg_en,
   input  logic                    ps_dg_dgsclt,
   input  logic                    ps_dg_mdfy,
   input  logic [DAG_IW-1:0]       ps_dg_iadd,
   input  logic [DAG_IW-1:0]       ps_dg_madd,
   input  logic                    ps_dg_wrt_en,
   input  logic [DAG_UAW-1:0]      ps_dg_wrt_add,
   input  logic [DAG_UAW-1:0]      ps_dg_rd_add,
   input  logic [AW-1:0]           bc_dt,
   output logic [AW-1:0]           dg_ps_add,
   output logic [AW-1:0]           dg_dm_add,
   output logic                    dg_add_vld,
   output logic [AW-1:0]           dg_bc_dt
);

   logic [AW-1:0] iReg_q [NREG];
   logic [AW-1:0] iReg_d [NREG];
   logic [AW-1:0] mReg_q [NREG];
   logic [AW-1:0] mReg_d [NREG];
`ifdef DAG_CIRC_BUF_EN
   logic [AW-1:0] lReg_q [NREG];
   logic [AW-1:0] lReg_d [NREG];
   logic [AW-1:0] bReg_q [NREG];
   logic [AW-1:0] bReg_d [NREG];
`endif

   logic [AW-1:0] addr_q;
   logic [AW-1:0] addr_d;
   logic          vld_q;
   logic          vld_d;

   ureg_addr_t    wrtDec;
   ureg_addr_t    rdDec;
   logic [AW-1:0] iSel;
   logic [AW-1:0] mSel;
   logic [AW-1:0] bSel;
   logic [AW-1:0] lSel;
   logic [AW-1:0] nxtAddr;
   logic [AW-1:0] rdData;
   logic          rdGrpStored;

   assign wrtDec = ureg_decode(ps_dg_wrt_add);
   assign rdDec  = ureg_decode(ps_dg_rd_add);

   // Generation operands come straight from the registers, never bypassed from a same-cycle write
   assign iSel = iReg_q[ps_dg_iadd];
   assign mSel = mReg_q[ps_dg_madd];
`ifdef DAG_CIRC_BUF_EN
   assign bSel = bReg_q[ps_dg_iadd];
   assign lSel = lReg_q[ps_dg_iadd];
`else
   assign bSel = '0;
   assign lSel = '0;
`endif

   dag_circ_mod #(
      .AW(AW)
   ) uCircMod (
      .idx_i  (iSel),
      .mod_i  (mSel),
      .base_i (bSel),
      .len_i  (lSel),
      .nxt_o  (nxtAddr)
   );

   // Ureg write is applied after the modify writeback so it wins a collision on the same I
   always_comb begin
      iReg_d = iReg_q;
      mReg_d = mReg_q;
`ifdef DAG_CIRC_BUF_EN
      lReg_d = lReg_q;
      bReg_d = bReg_q;
`endif
      addr_d = addr_q;
      vld_d  = 1'b0;
      if (ps_dg_en) begin
         vld_d  = 1'b1;
         addr_d = ps_dg_dgsclt ? nxtAddr : iSel;
         if (ps_dg_mdfy) begin
            iReg_d[ps_dg_iadd] = nxtAddr;
         end
      end
      if (ps_dg_wrt_en) begin
         case (wrtDec.grp)
            GRP_I:   iReg_d[wrtDec.idx] = bc_dt;
            GRP_M:   mReg_d[wrtDec.idx] = bc_dt;
`ifdef DAG_CIRC_BUF_EN
            GRP_L:   lReg_d[wrtDec.idx] = bc_dt;
            GRP_B:   bReg_d[wrtDec.idx] = bc_dt;
`endif
            default: ;
         endcase
      end
   end

`ifdef DAG_CIRC_BUF_EN
   assign rdGrpStored = 1'b1;
`else
   assign rdGrpStored = (rdDec.grp == GRP_I) || (rdDec.grp == GRP_M);
`endif

   always_comb begin
      rdData = '0;
      case (rdDec.grp)
         GRP_I:   rdData = iReg_q[rdDec.idx];
         GRP_M:   rdData = mReg_q[rdDec.idx];
`ifdef DAG_CIRC_BUF_EN
         GRP_L:   rdData = lReg_q[rdDec.idx];
         GRP_B:   rdData = bReg_q[rdDec.idx];
`endif
         default: rdData = '0;
      endcase
      if (ps_dg_wrt_en && (ps_dg_wrt_add == ps_dg_rd_add) && rdGrpStored) begin
         rdData = bc_dt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < NREG; k++) begin
            iReg_q[k] <= '0;
            mReg_q[k] <= '0;
`ifdef DAG_CIRC_BUF_EN
            lReg_q[k] <= '0;
            bReg_q[k] <= '0;
`endif
         end
         addr_q <= '0;
         vld_q  <= 1'b0;
      end else begin
         iReg_q <= iReg_d;
         mReg_q <= mReg_d;
`ifdef DAG_CIRC_BUF_EN
         lReg_q <= lReg_d;
         bReg_q <= bReg_d;
`endif
         addr_q <= addr_d;
         vld_q  <= vld_d;
      end
   end

   assign dg_ps_add  = addr_q;
   assign dg_dm_add  = addr_q;
   assign dg_add_vld = vld_q;
   assign dg_bc_dt   = rdData;

endmodule

// File: tb/tb_dag_addr_gen.sv
// Scoreboard testbench for dag_addr_gen; the circular-buffer scenario runs only when
// DAG_CIRC_BUF_EN is defined, otherwise the L/B-ignored behaviour is exercised.
module tb_dag_addr_gen;

`ifdef DAG_CIRC_BUF_EN
   localparam bit CIRC = 1'b1;
`else
   localparam bit CIRC = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        ps_dg_en;
   logic        ps_dg_dgsclt;
   logic        ps_dg_mdfy;
   logic [2:0]  ps_dg_iadd;
   logic [2:0]  ps_dg_madd;
   logic        ps_dg_wrt_en;
   logic [4:0]  ps_dg_wrt_add;
   logic [4:0]  ps_dg_rd_add;
   logic [15:0] bc_dt;
   logic [15:0] dg_ps_add;
   logic [15:0] dg_dm_add;
   logic        dg_add_vld;
   logic [15:0] dg_bc_dt;

   int checks = 0;
   int errors = 0;

   logic [15:0] expQ [$];
   logic [15:0] mI [8];
   logic [15:0] mM [8];
   logic [15:0] mL [8];
   logic [15:0] mB [8];

   dag_addr_gen dut (
      .clk           (clk),
      .rst           (rst),
      .ps_dg_en      (ps_dg_en),
      .ps_dg_dgsclt  (ps_dg_dgsclt),
      .ps_dg_mdfy    (ps_dg_mdfy),
      .ps_dg_iadd    (ps_dg_iadd),
      .ps_dg_madd    (ps_dg_madd),
      .ps_dg_wrt_en  (ps_dg_wrt_en),
      .ps_dg_wrt_add (ps_dg_wrt_add),
      .ps_dg_rd_add  (ps_dg_rd_add),
      .bc_dt         (bc_dt),
      .dg_ps_add     (dg_ps_add),
      .dg_dm_add     (dg_dm_add),
      .dg_add_vld    (dg_add_vld),
      .dg_bc_dt      (dg_bc_dt)
   );

   always #5 clk = ~clk;

   // Reference modify: signed M, mod 2^16, optional single-correction wrap into [B, B+L)
   function automatic logic [15:0] modelNxt(input logic [15:0] i, input logic [15:0] m,
                                            input logic [15:0] b, input logic [15:0] l);
      int raw;
      raw = int'(i) + int'($signed(m));
      if (CIRC && (l != 16'h0)) begin
         if (raw >= int'(b) + int'(l)) raw = raw - int'(l);
         else if (raw < int'(b)) raw = raw + int'(l);
      end
      return raw[15:0];
   endfunction

   function automatic void modelReset();
      for (int k = 0; k < 8; k++) begin
         mI[k] = '0;
         mM[k] = '0;
         mL[k] = '0;
         mB[k] = '0;
      end
   endfunction

   function automatic void modelWrite(input logic [4:0] a, input logic [15:0] d);
      case (a[4:3])
         2'b00: mI[a[2:0]] = d;
         2'b01: mM[a[2:0]] = d;
         2'b10: if (CIRC) mL[a[2:0]] = d;
         default: if (CIRC) mB[a[2:0]] = d;
      endcase
   endfunction

   // Registered outputs are compared mid-cycle against the scoreboard
   always @(negedge clk) begin
      if (dg_add_vld === 1'b1) begin
         logic [15:0] exp;
         checks++;
         if (expQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_vld: dg_dm_add=%h with empty scoreboard", dg_dm_add);
         end else begin
            exp = expQ.pop_front();
            if (dg_dm_add !== exp || dg_ps_add !== exp) begin
               errors++;
               $display("[TB] FAIL addr_out: dm=%h ps=%h expected %h", dg_dm_add, dg_ps_add, exp);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      ps_dg_en     = 1'b0;
      ps_dg_dgsclt = 1'b0;
      ps_dg_mdfy   = 1'b0;
      ps_dg_iadd   = '0;
      ps_dg_madd   = '0;
      ps_dg_wrt_en = 1'b0;
      ps_dg_wrt_add = '0;
      ps_dg_rd_add = '0;
      bc_dt        = '0;
   endtask

   task automatic uregWrite(input logic [4:0] a, input logic [15:0] d);
      ps_dg_wrt_en  = 1'b1;
      ps_dg_wrt_add = a;
      bc_dt         = d;
      tick();
      ps_dg_wrt_en  = 1'b0;
      modelWrite(a, d);
   endtask

   // One generation cycle: predict, push, update model, clock it in
   task automatic applyStimulus(input logic dgsclt, input logic mdfy,
                                input logic [2:0] iadd, input logic [2:0] madd);
      logic [15:0] nxt;
      nxt = modelNxt(mI[iadd], mM[madd], mB[iadd], mL[iadd]);
      expQ.push_back(dgsclt ? nxt : mI[iadd]);
      if (mdfy) mI[iadd] = nxt;
      ps_dg_en     = 1'b1;
      ps_dg_dgsclt = dgsclt;
      ps_dg_mdfy   = mdfy;
      ps_dg_iadd   = iadd;
      ps_dg_madd   = madd;
      tick();
      ps_dg_en     = 1'b0;
      ps_dg_mdfy   = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      modelReset();
      checks++;
      if (dg_add_vld !== 1'b0 || dg_ps_add !== 16'h0 || dg_dm_add !== 16'h0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: vld=%b ps=%h dm=%h expected 0/0000/0000",
                  dg_add_vld, dg_ps_add, dg_dm_add);
      end
      for (int a = 0; a < 32; a++) begin
         ps_dg_rd_add = 5'(a);
         #1;
         checks++;
         if (dg_bc_dt !== 16'h0) begin
            errors++;
            $display("[TB] FAIL reset_read[%0d]: got %h expected 0000", a, dg_bc_dt);
         end
      end
   endtask

   task automatic test_post_modify();
      uregWrite(5'b00_010, 16'h0100);
      uregWrite(5'b01_011, 16'h0004);
      applyStimulus(1'b0, 1'b1, 3'd2, 3'd3);
      ps_dg_rd_add = 5'b00_010;
      #1;
      checks++;
      if (dg_bc_dt !== 16'h0104) begin
         errors++;
         $display("[TB] FAIL post_mod_I2_first: got %h expected 0104", dg_bc_dt);
      end
      applyStimulus(1'b0, 1'b1, 3'd2, 3'd3);
      #1;
      checks++;
      if (dg_bc_dt !== 16'h0108) begin
         errors++;
         $display("[TB] FAIL post_mod_I2_second: got %h expected 0108", dg_bc_dt);
      end
      tick();
      checks++;
      if (dg_add_vld !== 1'b0 || dg_dm_add !== 16'h0104) begin
         errors++;
         $display("[TB] FAIL vld_idle_hold: vld=%b dm=%h expected 0/0104", dg_add_vld, dg_dm_add);
      end
   endtask

   task automatic test_pre_modify();
      uregWrite(5'b00_001, 16'hFFFE);
      uregWrite(5'b01_000, 16'h0003);
      applyStimulus(1'b1, 1'b0, 3'd1, 3'd0);
      ps_dg_rd_add = 5'b00_001;
      #1;
      checks++;
      if (dg_bc_dt !== 16'hFFFE) begin
         errors++;
         $display("[TB] FAIL pre_mod_I1_kept: got %h expected FFFE", dg_bc_dt);
      end
      tick();
   endtask

   task automatic test_collision();
      uregWrite(5'b00_100, 16'h0050);
      uregWrite(5'b01_010, 16'h0010);
      ps_dg_wrt_en  = 1'b1;
      ps_dg_wrt_add = 5'b00_100;
      ps_dg_rd_add  = 5'b00_100;
      bc_dt         = 16'h1234;
      #1;
      checks++;
      if (dg_bc_dt !== 16'h1234) begin
         errors++;
         $display("[TB] FAIL read_bypass: got %h expected 1234", dg_bc_dt);
      end
      modelWrite(5'b00_100, 16'h1234);
      expQ.push_back(16'h0050);
      ps_dg_en     = 1'b1;
      ps_dg_dgsclt = 1'b0;
      ps_dg_mdfy   = 1'b1;
      ps_dg_iadd   = 3'd4;
      ps_dg_madd   = 3'd2;
      tick();
      idle();
      ps_dg_rd_add = 5'b00_100;
      #1;
      checks++;
      if (dg_bc_dt !== 16'h1234) begin
         errors++;
         $display("[TB] FAIL collision_I4: got %h expected 1234", dg_bc_dt);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      uregWrite(5'b00_110, 16'h0010);
      uregWrite(5'b01_101, 16'hFFFF);
      for (int n = 0; n < 3; n++) applyStimulus(1'b0, 1'b1, 3'd6, 3'd5);
      applyStimulus(1'b1, 1'b0, 3'd6, 3'd5);
      ps_dg_rd_add = 5'b00_110;
      #1;
      checks++;
      if (dg_bc_dt !== 16'h000D) begin
         errors++;
         $display("[TB] FAIL back_to_back_I6: got %h expected 000D", dg_bc_dt);
      end
      tick();
   endtask

`ifdef DAG_CIRC_BUF_EN
   task automatic test_circ_buf();
      uregWrite(5'b11_101, 16'h0200);
      uregWrite(5'b10_101, 16'h0010);
      uregWrite(5'b00_101, 16'h020E);
      uregWrite(5'b01_001, 16'h0004);
      applyStimulus(1'b0, 1'b1, 3'd5, 3'd1);
      ps_dg_rd_add = 5'b00_101;
      #1;
      checks++;
      if (dg_bc_dt !== 16'h0202) begin
         errors++;
         $display("[TB] FAIL circ_wrap_high: got %h expected 0202", dg_bc_dt);
      end
      uregWrite(5'b01_001, 16'hFFF8);
      applyStimulus(1'b0, 1'b1, 3'd5, 3'd1);
      #1;
      checks++;
      if (dg_bc_dt !== 16'h020A) begin
         errors++;
         $display("[TB] FAIL circ_wrap_low: got %h expected 020A", dg_bc_dt);
      end
      tick();
   endtask
`else
   task automatic test_lb_ignored();
      uregWrite(5'b11_101, 16'h0200);
      uregWrite(5'b10_101, 16'h0010);
      ps_dg_rd_add = 5'b10_101;
      #1;
      checks++;
      if (dg_bc_dt !== 16'h0000) begin
         errors++;
         $display("[TB] FAIL L_read_zero: got %h expected 0000", dg_bc_dt);
      end
      ps_dg_wrt_en  = 1'b1;
      ps_dg_wrt_add = 5'b11_101;
      ps_dg_rd_add  = 5'b11_101;
      bc_dt         = 16'hBEEF;
      #1;
      checks++;
      if (dg_bc_dt !== 16'h0000) begin
         errors++;
         $display("[TB] FAIL B_bypass_zero: got %h expected 0000", dg_bc_dt);
      end
      ps_dg_wrt_en = 1'b0;
      uregWrite(5'b00_101, 16'h020E);
      uregWrite(5'b01_001, 16'h0004);
      applyStimulus(1'b0, 1'b1, 3'd5, 3'd1);
      ps_dg_rd_add = 5'b00_101;
      #1;
      checks++;
      if (dg_bc_dt !== 16'h0212) begin
         errors++;
         $display("[TB] FAIL linear_I5: got %h expected 0212", dg_bc_dt);
      end
      tick();
   endtask
`endif

   task automatic test_reset_mid();
      uregWrite(5'b00_111, 16'h0300);
      uregWrite(5'b01_100, 16'h0020);
      applyStimulus(1'b0, 1'b1, 3'd7, 3'd4);
      checks++;
      if (dg_add_vld !== 1'b1) begin
         errors++;
         $display("[TB] FAIL pre_reset_vld: got %b expected 1", dg_add_vld);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      modelReset();
      ps_dg_rd_add = 5'b00_111;
      #1;
      checks++;
      if (dg_add_vld !== 1'b0 || dg_dm_add !== 16'h0 || dg_ps_add !== 16'h0 || dg_bc_dt !== 16'h0) begin
         errors++;
         $display("[TB] FAIL reset_mid: vld=%b dm=%h ps=%h I7=%h expected 0/0000/0000/0000",
                  dg_add_vld, dg_dm_add, dg_ps_add, dg_bc_dt);
      end
      uregWrite(5'b00_111, 16'h0300);
      uregWrite(5'b01_100, 16'h0020);
      ps_dg_en   = 1'b1;
      ps_dg_mdfy = 1'b1;
      ps_dg_iadd = 3'd7;
      ps_dg_madd = 3'd4;
      rst        = 1'b1;
      tick();
      rst = 1'b0;
      idle();
      modelReset();
      ps_dg_rd_add = 5'b00_111;
      #1;
      checks++;
      if (dg_add_vld !== 1'b0 || dg_bc_dt !== 16'h0) begin
         errors++;
         $display("[TB] FAIL reset_with_en: vld=%b I7=%h expected 0/0000", dg_add_vld, dg_bc_dt);
      end
      tick();
   endtask

   initial begin
      idle();
      rst = 1'b1;
      modelReset();
      test_reset();
      test_post_modify();
      test_pre_modify();
      test_collision();
      test_back_to_back();
`ifdef DAG_CIRC_BUF_EN
      test_circ_buf();
`else
      test_lb_ignored();
`endif
      test_reset_mid();
      tick();
      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL scoreboard_drain: %0d entries left expected 0", expQ.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
